// File: rtl/series_pkg.sv
// Shared widths and result record for the series-evaluation datapath and its consumers.
package series_pkg;

  localparam int Y_W   = 32;
  localparam int TAG_W = 4;
  localparam int CNT_W = 8;

  localparam logic [Y_W-1:0] Y_SAT = '1;

  typedef struct packed {
    logic [Y_W-1:0]   y;
    logic             ovf;
    logic             vflag;
    logic [TAG_W-1:0] tag;
  } result_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head read and an explicit occupancy register.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  import series_pkg::*;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   level_reg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign level = level_reg;
  assign full  = (level_reg == (AW + 1)'(DEPTH));
  assign empty = (level_reg == '0);

endmodule

// File: rtl/result_collector.sv
// Captures datapath results on a done strobe, tags and buffers them, and keeps status counters.
module result_collector #(
  parameter int DEPTH = 4,
  parameter int Y_W   = series_pkg::Y_W,
  parameter int TAG_W = series_pkg::TAG_W,
  parameter int CNT_W = series_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     in_done,
  input  logic [Y_W-1:0]           in_y,
  input  logic                     in_ovf,
  input  logic                     in_vflag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Y_W-1:0]           out_y,
  output logic                     out_ovf,
  output logic                     out_vflag,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);
  import series_pkg::*;

  localparam int EW = Y_W + 2 + TAG_W;

  logic [TAG_W-1:0] tag_reg;
  logic [CNT_W-1:0] ovf_cnt_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic             clear;
  logic             pop;
  logic             push;
  logic             drop;
  logic [Y_W-1:0]   y_sat;
  logic [EW-1:0]    din;
  logic [EW-1:0]    dout;

  assign clear = rst | init;
  assign pop   = !empty && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push  = in_done && (!full || pop) && !clear;
  assign drop  = in_done && full && !pop && !clear;
  assign y_sat = in_ovf ? {Y_W{1'b1}} : in_y;
  assign din   = {y_sat, in_ovf, in_vflag, tag_reg};

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (init),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      tag_reg      <= '0;
      ovf_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (in_done) tag_reg <= tag_reg + 1'b1;
      if (push && in_ovf && (ovf_cnt_reg != '1)) ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
      if (drop && (drop_cnt_reg != '1)) drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign out_valid = !empty;
  assign {out_y, out_ovf, out_vflag, out_tag} = empty ? '0 : dout;
  assign ovf_cnt   = ovf_cnt_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: vector table plus scoreboarded corner-case sequences.
module tb_result_collector;
  import series_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, init, in_done, in_ovf, in_vflag, out_ready;
  logic [Y_W-1:0]   in_y;
  logic             out_valid, out_ovf, out_vflag, full, empty;
  logic [Y_W-1:0]   out_y;
  logic [TAG_W-1:0] out_tag;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0] ovf_cnt, drop_cnt;

  int checks = 0;
  int failures = 0;

  result_t sb_q[$];
  int m_tag = 0;
  int m_ovf = 0;
  int m_drop = 0;

  always #5 clk = ~clk;

  result_collector #(.DEPTH(DEPTH), .Y_W(Y_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .init(init), .in_done(in_done), .in_y(in_y),
    .in_ovf(in_ovf), .in_vflag(in_vflag), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_ovf(out_ovf), .out_vflag(out_vflag), .out_tag(out_tag),
    .full(full), .empty(empty), .level(level), .ovf_cnt(ovf_cnt), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle starting and ending at a falling edge; head checked before, state after.
  task automatic step(input logic d, input logic [Y_W-1:0] y, input logic o, input logic v,
                      input logic r, input logic i, input logic rs);
    result_t e;
    int sz;
    chk("out_valid", out_valid, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      chk("head_y", out_y, sb_q[0].y);
      chk("head_ovf", out_ovf, sb_q[0].ovf);
      chk("head_vflag", out_vflag, sb_q[0].vflag);
      chk("head_tag", out_tag, sb_q[0].tag);
    end else begin
      chk("idle_head", {out_y, out_ovf, out_vflag, out_tag}, 64'd0);
    end
    in_done = d; in_y = y; in_ovf = o; in_vflag = v; out_ready = r; init = i; rst = rs;
    if (rs || i) begin
      sb_q.delete();
      m_tag = 0; m_ovf = 0; m_drop = 0;
    end else begin
      if (r && sb_q.size() != 0) void'(sb_q.pop_front());
      if (d) begin
        if (sb_q.size() < DEPTH) begin
          e.y = o ? Y_SAT : y;
          e.ovf = o; e.vflag = v; e.tag = TAG_W'(m_tag);
          sb_q.push_back(e);
          if (o && m_ovf < CNT_MAX) m_ovf++;
        end else if (m_drop < CNT_MAX) begin
          m_drop++;
        end
        m_tag = (m_tag + 1) % (1 << TAG_W);
      end
    end
    @(posedge clk);
    @(negedge clk);
    sz = sb_q.size();
    $display("step d=%0b y=0x%0h ovf=%0b rdy=%0b init=%0b rst=%0b -> level=%0d tag=%0d ovf_cnt=%0d drop_cnt=%0d",
             d, y, o, r, i, rs, level, out_tag, ovf_cnt, drop_cnt);
    chk("level", level, sz);
    chk("empty", empty, sz == 0);
    chk("full", full, sz == DEPTH);
    chk("ovf_cnt", ovf_cnt, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  typedef struct {
    logic           d;
    logic [Y_W-1:0] y;
    logic           o;
    logic           r;
    int             exp_level;
    logic [Y_W-1:0] exp_y;
    int             exp_tag;
    int             exp_ovf_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst = 1'b1; init = 1'b0; in_done = 1'b0; in_y = '0; in_ovf = 1'b0;
    in_vflag = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    step(1'b1, 32'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_empty", empty, 1'b1);

    // Basic ordering, then a saturated overflow entry.
    vecs[0] = '{1'b1, 32'h10,   1'b0, 1'b0, 1, 32'h10, 0, 0};
    vecs[1] = '{1'b1, 32'h20,   1'b0, 1'b0, 2, 32'h10, 0, 0};
    vecs[2] = '{1'b1, 32'h30,   1'b0, 1'b0, 3, 32'h10, 0, 0};
    vecs[3] = '{1'b0, 32'h0,    1'b0, 1'b1, 2, 32'h20, 1, 0};
    vecs[4] = '{1'b0, 32'h0,    1'b0, 1'b1, 1, 32'h30, 2, 0};
    vecs[5] = '{1'b0, 32'h0,    1'b0, 1'b1, 0, 32'h0,  0, 0};
    vecs[6] = '{1'b1, 32'h1234, 1'b1, 1'b0, 1, 32'hFFFF_FFFF, 3, 1};
    vecs[7] = '{1'b0, 32'h0,    1'b0, 1'b1, 0, 32'h0,  0, 1};
    for (int k = 0; k < 8; k++) begin
      step(vecs[k].d, vecs[k].y, vecs[k].o, 1'b1, vecs[k].r, 1'b0, 1'b0);
      chk("vec_level", level, vecs[k].exp_level);
      chk("vec_y", out_y, vecs[k].exp_y);
      chk("vec_tag", out_tag, vecs[k].exp_tag);
      chk("vec_ovf_cnt", ovf_cnt, vecs[k].exp_ovf_cnt);
    end

    // Full and drop: six strobes into four slots.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, 32'h100 + k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_full", full, 1'b1);
    chk("drop_level", level, DEPTH);
    chk("drop_cnt2", drop_cnt, 2);
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tag_gap", out_tag, 6);

    // Full with simultaneous pop: accepted, lands last.
    for (int k = 0; k < 3; k++) step(1'b1, 32'h300 + k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fullpop_level", level, DEPTH);
    chk("fullpop_drop", drop_cnt, 2);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fullpop_last", out_y, 32'hAAAA);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Flush, then reset, mid-operation with a same-cycle strobe.
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 3; k++) step(1'b1, 32'h400 + k, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h4FF, 1'b0, 1'b0, 1'b0, pass == 0, pass == 1);
      chk("flush_empty", empty, 1'b1);
      chk("flush_level", level, 0);
      chk("flush_ovf", ovf_cnt, 0);
      chk("flush_drop", drop_cnt, 0);
      step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("flush_tag", out_tag, 0);
      chk("flush_y", out_y, 32'h500);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Tag wrap over 17 accepted strobes, then drop-counter saturation.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 17; k++) step(1'b1, 32'h600 + k, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wrap_tag", out_tag, 0);
    chk("wrap_y", out_y, 32'h610);
    for (int k = 0; k < 3; k++) step(1'b1, 32'h700 + k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) step(1'b1, 32'h800 + k, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_drop", drop_cnt, CNT_MAX);
    chk("sat_ovf", ovf_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
